latch_bank_arbiter: RTL
=======================

Name: latch_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared bank of DEPTH level-sensitive D latches, each WIDTH bits wide.
- Accepts write requests from NREQ clients and grants one at a time.
- Drives the bank's per-entry enables (E) and shared data bus (D) with a glitch-free setup/enable/hold sequence, so the latches are never transparent while D is changing.
- Sits between client logic and the latch bank.

Parameters:
- NREQ, 4, number of requesting clients (2..8)
- WIDTH, 8, data width of each latch entry
- DEPTH, 4, number of latch entries in the bank
- AW, 2, entry address width; must satisfy 2**AW >= DEPTH
- EN_CYCLES, 1, number of clock cycles E is held high (1..4)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-client write request, level
- req_addr  input  NREQ*AW  per-client target entry, client i in bits [i*AW +: AW]
- req_data  input  NREQ*WIDTH  per-client write data, client i in bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, high from SETUP through HOLD
- ack  output  NREQ  one-hot, one-cycle completion pulse
- addr_err  output  1  one-cycle pulse with ack when the granted address is >= DEPTH
- busy  output  1  high whenever state != IDLE
- latch_e  output  DEPTH  per-entry latch enable, driven directly from a register
- latch_d  output  WIDTH  shared latch data bus, registered

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE; round-robin pointer ptr=0.
  - gnt, ack, addr_err, busy, latch_e and latch_d are all 0.
  - latch_e falls immediately on rst_n assertion, including mid-sequence; the interrupted write is abandoned with no ack.
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE:
  - If req is nonzero, select the first asserted client searching ptr, ptr+1, ... modulo NREQ.
  - Capture that client's index g, addr and data; go to SETUP.
  - Otherwise remain in IDLE.
- SETUP (1 cycle):
  - gnt[g]=1; latch_d=captured data; latch_e=0.
- ENABLE (EN_CYCLES cycles, counted by an internal counter):
  - latch_e[addr]=1; all other enable bits 0.
  - latch_d is held stable.
  - If addr >= DEPTH, latch_e stays all 0.
- HOLD (1 cycle):
  - latch_e=0; latch_d still held; gnt[g]=1; ack[g]=1.
  - addr_err=1 if addr >= DEPTH.
  - ptr <= (g+1) mod NREQ.
  - Next state is IDLE.
- latch_d keeps its last value in IDLE; it is not cleared.
- Timing, with req sampled high in IDLE at cycle 0:
  - SETUP at cycle 1.
  - latch_e high for cycles 2 .. 1+EN_CYCLES.
  - HOLD and ack at cycle 2+EN_CYCLES.
  - IDLE at cycle 3+EN_CYCLES, and can grant again on that same cycle.
  - Throughput is one write per 3+EN_CYCLES cycles.
- Client rules:
  - addr and data are sampled only at grant; later changes are ignored.
  - A transaction is committed once granted; dropping req mid-sequence does not abort it.
  - A client must deassert req in the cycle after its ack. Otherwise it is treated as a new request, arbitrated at lower priority than the other clients.
- Arbitration (round robin, NREQ=4, ptr=0):
  - Simultaneous req from all clients → grant order 0, 1, 2, 3, 0, ...
  - A lone requester is re-granted back to back with no idle cycle.
- Requests arriving while busy are held off; gnt stays 0 for those clients until they win arbitration.

Optional Feature:
- Macro: LATCH_READBACK_EN.
- Defined:
  - Adds input latch_q, DEPTH*WIDTH bits, carrying the bank's Q outputs (entry j in bits [j*WIDTH +: WIDTH]).
  - Adds output rd_err, 1 bit, reset 0.
  - In HOLD, if addr < DEPTH and latch_q entry addr != captured data, rd_err pulses together with ack.
- Undefined: no latch_q or rd_err ports and no compare logic; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → all outputs 0. Release reset → first grant goes to client 0: gnt=4'b0001 at cycle 1, latch_e=4'b0001 at cycle 2 for addr 0.
- Single write, EN_CYCLES=1: client 2 writes addr=3, data=8'hA5 → latch_d=8'hA5 from cycle 1; latch_e=4'b1000 for exactly cycle 2 only; ack=4'b0100 at cycle 3; busy low at cycle 4.
- Fairness: req=4'b1111 held, each client dropping req after its ack → ack order client 0, 1, 2, 3, one ack every 4 cycles; no client granted twice before all four are served.
- Bad address: client 1 requests addr=2'b11 with DEPTH=3 → latch_e stays 0 for the whole sequence; ack=4'b0010 and addr_err=1 in the same cycle.
- Reset mid-operation: assert rst_n=0 while latch_e=4'b0100 → latch_e=0 within the same cycle, no ack produced. After release, a pending req is re-arbitrated from ptr=0.
- LATCH_READBACK_EN defined: the bench latch model holds entry 1 stuck at 8'h00; client 0 writes 8'h3C to addr 1 → rd_err=1 with ack=4'b0001. Writing 8'h00 to the same entry → rd_err=0.

Source files
------------

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//   Round-robin arbiter and write sequencer for a shared bank of DEPTH
//   level-sensitive D latches (WIDTH bits each). One client is granted at a
//   time; the bank is driven through a SETUP / ENABLE / HOLD sequence so that
//   latch_d is stable whenever any latch_e bit is high.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-client write request (level)
//   req_addr   per-client target entry, client i at [i*AW +: AW]
//   req_data   per-client write data, client i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant, SETUP through HOLD
//   ack        one-hot completion pulse in HOLD
//   addr_err   pulses with ack when the granted address is >= DEPTH
//   busy       high whenever the sequencer is not idle
//   latch_e    per-entry latch enable (registered)
//   latch_d    shared latch data bus (registered)
//   latch_q    bank Q outputs, entry j at [j*WIDTH +: WIDTH]  (LATCH_READBACK_EN)
//   rd_err     pulses with ack when read-back differs        (LATCH_READBACK_EN)
//
// Build option: define LATCH_READBACK_EN to add the read-back compare.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | arbitrate among req, capture winner's index/addr/data
// S_SETUP  | data driven on latch_d, enables low
// S_ENABLE | latch_e[addr] high for EN_CYCLES cycles, data held
// S_HOLD   | enables low, data held, ack (+ addr_err / rd_err), advance ptr

module latch_bank_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AW        = 2,
   parameter int EN_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*AW-1:0]      req_addr,
   input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef LATCH_READBACK_EN
   input  logic [DEPTH*WIDTH-1:0]  latch_q,
   output logic                    rd_err,
`endif
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         ack,
   output logic                    addr_err,
   output logic                    busy,
   output logic [DEPTH-1:0]        latch_e,
   output logic [WIDTH-1:0]        latch_d
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [GW-1:0]     r_ptr;
   logic [GW-1:0]     r_gidx;
   logic [AW-1:0]     r_addr;
   logic [WIDTH-1:0]  r_latch_d;
   logic [DEPTH-1:0]  r_latch_e;
   logic [CW-1:0]     r_cnt;

   logic [2*NREQ-1:0] w_req_rot;
   logic [GW:0]       w_sum;
   logic [GW-1:0]     w_sel;
   logic [AW-1:0]     w_sel_addr;
   logic [WIDTH-1:0]  w_sel_data;
   logic [DEPTH-1:0]  w_e_dec;
   logic              w_any_req;
   logic              w_addr_bad;

   // Rotate requests so bit k is client (ptr+k) mod NREQ; lowest set bit wins.
   assign w_req_rot = {req, req} >> r_ptr;
   assign w_any_req = |req;

   always_comb begin
      w_sum = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (w_req_rot[k]) w_sum = {1'b0, r_ptr} + (GW+1)'(k);
      end
      if (w_sum >= (GW+1)'(NREQ)) w_sum = w_sum - (GW+1)'(NREQ);
   end

   assign w_sel = w_sum[GW-1:0];

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (w_sel == GW'(j)) begin
            w_sel_addr = req_addr[j*AW +: AW];
            w_sel_data = req_data[j*WIDTH +: WIDTH];
         end
      end
   end

   // Out-of-range addresses match no entry, so the decode is all zeros.
   always_comb begin
      w_e_dec = '0;
      for (int j = 0; j < DEPTH; j++) begin
         w_e_dec[j] = (r_addr == AW'(j));
      end
   end

   assign w_addr_bad = ({1'b0, r_addr} >= (AW+1)'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_state_nxt = S_SETUP;
         S_SETUP:  w_state_nxt = S_ENABLE;
         S_ENABLE: if (r_cnt == '0) w_state_nxt = S_HOLD;
         S_HOLD:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_gidx    <= '0;
         r_addr    <= '0;
         r_latch_d <= '0;
         r_latch_e <= '0;
         r_cnt     <= '0;
      end else begin
         if (r_state == S_IDLE && w_any_req) begin
            r_gidx    <= w_sel;
            r_addr    <= w_sel_addr;
            r_latch_d <= w_sel_data;
         end
         if (r_state == S_SETUP)                      r_cnt <= CW'(EN_CYCLES-1);
         else if (r_state == S_ENABLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         if (r_state == S_HOLD) begin
            r_ptr <= (r_gidx == GW'(NREQ-1)) ? '0 : r_gidx + 1'b1;
         end
         // Enable is registered from the next state so it rises one cycle
         // after data settles and falls one cycle before data may change.
         r_latch_e <= (w_state_nxt == S_ENABLE) ? w_e_dec : '0;
      end
   end

   always_comb begin
      gnt      = '0;
      ack      = '0;
      addr_err = 1'b0;
      busy     = (r_state != S_IDLE);
      for (int j = 0; j < NREQ; j++) begin
         gnt[j] = (r_state != S_IDLE) && (r_gidx == GW'(j));
         ack[j] = (r_state == S_HOLD) && (r_gidx == GW'(j));
      end
      if (r_state == S_HOLD) addr_err = w_addr_bad;
   end

   assign latch_e = r_latch_e;
   assign latch_d = r_latch_d;

`ifdef LATCH_READBACK_EN
   logic [WIDTH-1:0] w_q_sel;

   always_comb begin
      w_q_sel = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (r_addr == AW'(j)) w_q_sel = latch_q[j*WIDTH +: WIDTH];
      end
   end

   assign rd_err = (r_state == S_HOLD) && !w_addr_bad && (w_q_sel != r_latch_d);
`endif

endmodule
